hazard_scheduler: RTL and testbench

- Pipeline hazard controller for the 5-stage MIPS core (IF/ID/EX/MEM/WB).
- Takes the operand-usage flags decoded in ID (rs-used / rt-used) plus the register fields of the ID instruction.
- Keeps an internal shadow of the destination-register info for the EX, MEM and WB stages.
- Drives the PC/IF-ID stall, the ID/EX bubble, branch flushes and the EX-stage forwarding selects, and keeps stall/flush statistics counters.

---
 rtl/hazard_scheduler.sv | 113 +++++++++++
 tb/tb_hazard_scheduler.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scheduler.sv
// Hazard controller for the 5-stage MIPS pipeline: load-use stall, branch
// flush, EX-stage forwarding selects and saturating stall/flush statistics.
module hazard_scheduler #(
  parameter int CNT_W  = 16,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              id_valid,
  input  logic              id_r1_used,
  input  logic              id_r2_used,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_reg_write,
  input  logic              id_is_load,
  input  logic              ex_branch_taken,
  output logic              stall,
  output logic              bubble,
  output logic              flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_e;

  // Writer info carried by every shadow stage.
  typedef struct packed {
    logic              valid;
    logic              we;
    logic              load;
    logic [REG_AW-1:0] dst;
  } wr_t;

  // EX additionally remembers its source operands for forwarding.
  typedef struct packed {
    wr_t               w;
    logic              r1u;
    logic              r2u;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
  } ex_t;

  ex_t  ex_q;
  ex_t  id_entry;
  wr_t  mem_q;
  wr_t  wb_q;
  logic luh;

  // Register 0 is hardwired, so writing it never creates a dependency.
  function automatic logic can_write(input wr_t s);
    return s.valid & s.we & (s.dst != '0);
  endfunction

  function automatic fwd_e fwd_sel(input logic used, input logic [REG_AW-1:0] src,
                                   input wr_t mem, input wr_t wb);
    if (used && can_write(mem) && !mem.load && mem.dst == src) return FWD_MEM;
    if (used && can_write(wb) && wb.dst == src)                return FWD_WB;
    return FWD_RF;
  endfunction

  assign luh = id_valid & can_write(ex_q.w) & ex_q.w.load &
               ((id_r1_used & (id_rs == ex_q.w.dst)) |
                (id_r2_used & (id_rt == ex_q.w.dst)));

  // A taken branch squashes the ID instruction, so its hazard is irrelevant.
  assign flush  = en & ex_branch_taken;
  assign stall  = en & luh & ~flush;
  assign bubble = stall;

  assign fwd_a = ex_q.w.valid ? fwd_sel(ex_q.r1u, ex_q.rs, mem_q, wb_q) : FWD_RF;
  assign fwd_b = ex_q.w.valid ? fwd_sel(ex_q.r2u, ex_q.rt, mem_q, wb_q) : FWD_RF;

  always_comb begin
    // NOTE: default assignment first so every path drives id_entry; no latch.
    id_entry = '0;
    if (id_valid && !stall && !flush) begin
      id_entry.w.valid = 1'b1;
      id_entry.w.we    = id_reg_write;
      id_entry.w.load  = id_is_load;
      id_entry.w.dst   = id_dst;
      id_entry.r1u     = id_r1_used;
      id_entry.r2u     = id_r2_used;
      id_entry.rs      = id_rs;
      id_entry.rt      = id_rt;
    end
  end

  // NOTE: non-blocking assignments so WB/MEM/EX all shift on the old values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (en) begin
      wb_q  <= mem_q;
      mem_q <= ex_q.w;
      ex_q  <= id_entry;
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (flush && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed bench for hazard_scheduler: load-use, forwarding, reg0, flush,
// freeze/reset and counter saturation (second instance with CNT_W=2).
module tb_hazard_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       id_valid, id_r1_used, id_r2_used;
  logic [4:0] id_rs, id_rt, id_dst;
  logic       id_reg_write, id_is_load, ex_branch_taken;

  logic        stall, bubble, flush;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt, flush_cnt;
  logic        stall2, bubble2, flush2;
  logic [1:0]  fwd_a2, fwd_b2;
  logic [1:0]  stall_cnt2, flush_cnt2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hazard_scheduler #(.CNT_W(16), .REG_AW(5)) d16 (
    .clk(clk), .rst_n(rst_n), .en(en), .id_valid(id_valid),
    .id_r1_used(id_r1_used), .id_r2_used(id_r2_used),
    .id_rs(id_rs), .id_rt(id_rt), .id_dst(id_dst),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .ex_branch_taken(ex_branch_taken),
    .stall(stall), .bubble(bubble), .flush(flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_scheduler #(.CNT_W(2), .REG_AW(5)) d2 (
    .clk(clk), .rst_n(rst_n), .en(en), .id_valid(id_valid),
    .id_r1_used(id_r1_used), .id_r2_used(id_r2_used),
    .id_rs(id_rs), .id_rt(id_rt), .id_dst(id_dst),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .ex_branch_taken(ex_branch_taken),
    .stall(stall2), .bubble(bubble2), .flush(flush2),
    .fwd_a(fwd_a2), .fwd_b(fwd_b2), .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic r1u, input logic r2u,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dst,
                        input logic we, input logic ld);
    id_valid = v; id_r1_used = r1u; id_r2_used = r2u;
    id_rs = rs; id_rt = rt; id_dst = dst; id_reg_write = we; id_is_load = ld;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // A load sitting in MEM must never be the forwarding source.
  always @(negedge clk) begin
    if (rst_n && fwd_a == 2'b10) check("fwd_a_src_not_load", {31'b0, d16.mem_q.load}, 32'd0);
    if (rst_n && fwd_b == 2'b10) check("fwd_b_src_not_load", {31'b0, d16.mem_q.load}, 32'd0);
  end

  initial begin
    rst_n = 1'b0; en = 1'b1; ex_branch_taken = 1'b0;
    set_id(1, 1, 1, 5'd8, 5'd8, 5'd3, 1, 1);
    check("rst_stall", {31'b0, stall}, 0);
    check("rst_flush", {31'b0, flush}, 0);
    check("rst_fwd_a", {30'b0, fwd_a}, 0);
    check("rst_fwd_b", {30'b0, fwd_b}, 0);
    check("rst_stall_cnt", {16'b0, stall_cnt}, 0);
    check("rst_flush_cnt", {16'b0, flush_cnt}, 0);
    tick();
    rst_n = 1'b1;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // 1. lw $8,0($1) then add $10,$8,$2
    set_id(1, 1, 0, 5'd1, 5'd0, 5'd8, 1, 1);
    check("t1_no_stall_lw", {31'b0, stall}, 0);
    tick();
    set_id(1, 1, 1, 5'd8, 5'd2, 5'd10, 1, 0);
    check("t1_stall", {31'b0, stall}, 1);
    check("t1_bubble", {31'b0, bubble}, 1);
    check("t1_flush", {31'b0, flush}, 0);
    tick();
    check("t1_stall_released", {31'b0, stall}, 0);
    check("t1_ex_bubble_fwd_a", {30'b0, fwd_a}, 0);
    check("t1_stall_cnt", {16'b0, stall_cnt}, 1);
    tick();
    check("t1_fwd_a_wb", {30'b0, fwd_a}, 2'b01);
    check("t1_fwd_b_rf", {30'b0, fwd_b}, 2'b00);

    // 2. add $9,$3,$4 ; sub $11,$5,$9
    set_id(1, 1, 1, 5'd3, 5'd4, 5'd9, 1, 0);
    tick();
    set_id(1, 1, 1, 5'd5, 5'd9, 5'd11, 1, 0);
    check("t2_no_stall", {31'b0, stall}, 0);
    tick();
    check("t2_fwd_b_mem", {30'b0, fwd_b}, 2'b10);
    check("t2_fwd_a_rf", {30'b0, fwd_a}, 2'b00);
    set_id(1, 1, 1, 5'd3, 5'd4, 5'd9, 1, 0);
    tick();
    set_id(1, 1, 1, 5'd6, 5'd7, 5'd12, 1, 0);
    tick();
    set_id(1, 1, 1, 5'd5, 5'd9, 5'd11, 1, 0);
    tick();
    check("t2_fwd_b_wb", {30'b0, fwd_b}, 2'b01);
    set_id(1, 1, 1, 5'd3, 5'd4, 5'd9, 1, 0);
    tick();
    set_id(1, 1, 1, 5'd3, 5'd4, 5'd9, 1, 0);
    tick();
    set_id(1, 1, 1, 5'd9, 5'd9, 5'd11, 1, 0);
    tick();
    check("t2_mem_wins_a", {30'b0, fwd_a}, 2'b10);
    check("t2_mem_wins_b", {30'b0, fwd_b}, 2'b10);

    // 3. register 0 and unused operands
    set_id(1, 1, 1, 5'd3, 5'd4, 5'd0, 1, 0);
    tick();
    set_id(1, 1, 1, 5'd0, 5'd0, 5'd13, 1, 0);
    tick();
    check("t3_r0_mem_fwd_a", {30'b0, fwd_a}, 0);
    check("t3_r0_mem_fwd_b", {30'b0, fwd_b}, 0);
    set_id(1, 1, 0, 5'd1, 5'd0, 5'd0, 1, 1);
    tick();
    set_id(1, 1, 1, 5'd0, 5'd0, 5'd13, 1, 0);
    check("t3_r0_load_no_stall", {31'b0, stall}, 0);
    tick();
    set_id(1, 1, 0, 5'd1, 5'd0, 5'd8, 1, 1);
    tick();
    set_id(1, 0, 1, 5'd8, 5'd2, 5'd14, 1, 0);
    check("t3_unused_rs_no_stall", {31'b0, stall}, 0);
    tick();

    // 4. add $9 ; lw $8 ; consumer of $8 and $9 squashed by a taken branch
    set_id(1, 1, 1, 5'd3, 5'd4, 5'd9, 1, 0);
    tick();
    set_id(1, 1, 0, 5'd1, 5'd0, 5'd8, 1, 1);
    tick();
    set_id(1, 1, 1, 5'd8, 5'd9, 5'd15, 1, 0);
    ex_branch_taken = 1'b1;
    #1;
    check("t4_flush", {31'b0, flush}, 1);
    check("t4_stall_suppressed", {31'b0, stall}, 0);
    check("t4_bubble_suppressed", {31'b0, bubble}, 0);
    tick();
    ex_branch_taken = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    check("t4_flush_cnt", {16'b0, flush_cnt}, 1);
    check("t4_stall_cnt_held", {16'b0, stall_cnt}, 1);
    check("t4_ex_bubble_fwd_a", {30'b0, fwd_a}, 0);
    check("t4_ex_bubble_fwd_b", {30'b0, fwd_b}, 0);
    tick();

    // 5. add $9 ; lw $8,0($9) ; freeze with a pending hazard and a branch
    set_id(1, 1, 1, 5'd3, 5'd4, 5'd9, 1, 0);
    tick();
    set_id(1, 1, 0, 5'd9, 5'd0, 5'd8, 1, 1);
    tick();
    check("t5_lw_base_fwd", {30'b0, fwd_a}, 2'b10);
    set_id(1, 1, 0, 5'd8, 5'd0, 5'd10, 1, 0);
    en = 1'b0;
    ex_branch_taken = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("t5_frz_stall", {31'b0, stall}, 0);
      check("t5_frz_bubble", {31'b0, bubble}, 0);
      check("t5_frz_flush", {31'b0, flush}, 0);
      check("t5_frz_fwd_a", {30'b0, fwd_a}, 2'b10);
      check("t5_frz_cnts", {stall_cnt, flush_cnt}, {16'd1, 16'd1});
      tick();
    end
    en = 1'b1;
    ex_branch_taken = 1'b0;
    #1;
    check("t5_hazard_held", {31'b0, stall}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_stall", {31'b0, stall}, 0);
    check("t5_rst_bubble", {31'b0, bubble}, 0);
    check("t5_rst_fwd_a", {30'b0, fwd_a}, 0);
    check("t5_rst_stall_cnt", {16'b0, stall_cnt}, 0);
    check("t5_rst_flush_cnt", {16'b0, flush_cnt}, 0);
    check("t5_rst_stall_cnt2", {30'b0, stall_cnt2}, 0);
    #2;
    rst_n = 1'b1;
    #1;
    check("t5_post_rst_no_stall", {31'b0, stall}, 0);
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // 6. six load-use pairs: 16-bit counter counts, 2-bit counter saturates
    for (int i = 0; i < 6; i++) begin
      set_id(1, 1, 0, 5'd1, 5'd0, 5'd8, 1, 1);
      tick();
      set_id(1, 0, 1, 5'd0, 5'd8, 5'd10, 1, 0);
      check("t6_stall", {31'b0, stall}, 1);
      tick();
      check("t6_one_cycle", {31'b0, stall}, 0);
      check("t6_cnt16", {16'b0, stall_cnt}, i + 1);
      check("t6_cnt2_sat", {30'b0, stall_cnt2}, (i + 1 > 3) ? 3 : i + 1);
      tick();
      check("t6_consumer_fwd_b", {30'b0, fwd_b}, 2'b01);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
